control_multi_wait: RTL and testbench



---
 rtl/control_multi_wait_pkg.sv | 71 +++++++
 rtl/control_multi_wait_if.sv | 34 +++
 rtl/control_multi_wait_mem_wait_counter.sv | 32 +++
 rtl/control_multi_wait.sv | 171 +++++++++++++++++
 tb/tb_control_multi_wait.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_multi_wait_pkg.sv
// Shared encodings for the multicycle RISC-V controller: opcodes, states,
// datapath mux/ALUOp codes and the packed control word.
package control_multi_wait_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_ADDR    = 4'd2,
    ST_LW      = 4'd3,
    ST_LWWB    = 4'd4,
    ST_SW      = 4'd5,
    ST_RTYPE   = 4'd6,
    ST_OPIMM   = 4'd7,
    ST_LUI     = 4'd8,
    ST_AUIPC   = 4'd9,
    ST_ALUWB   = 4'd10,
    ST_BRANCH  = 4'd11,
    ST_JAL     = 4'd12,
    ST_JALR    = 4'd13,
    ST_ILLEGAL = 4'd14
  } state_t;

  localparam logic [1:0] ORIGA_PCBACK = 2'b00;
  localparam logic [1:0] ORIGA_RS1    = 2'b01;
  localparam logic [1:0] ORIGA_PC     = 2'b10;

  localparam logic [1:0] ORIGB_RS2    = 2'b00;
  localparam logic [1:0] ORIGB_FOUR   = 2'b01;
  localparam logic [1:0] ORIGB_IMM    = 2'b10;

  localparam logic [1:0] M2R_ALUOUT   = 2'b00;
  localparam logic [1:0] M2R_PC4      = 2'b01;
  localparam logic [1:0] M2R_MDR      = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_LUI    = 2'b11;

  typedef struct packed {
    logic       escreveIR;
    logic       escrevePC;
    logic       escrevePCCond;
    logic       escrevePCBack;
    logic [1:0] origAULA;
    logic [1:0] origBULA;
    logic [1:0] mem2Reg;
    logic       origPC;
    logic       iouD;
    logic       regWrite;
    logic       memWrite;
    logic       memRead;
    logic [1:0] aluOp;
    logic       illegal;
  } ctrl_t;

  function automatic logic isAccess(state_t s);
    return (s == ST_FETCH) || (s == ST_LW) || (s == ST_SW);
  endfunction

endpackage

// File: rtl/control_multi_wait_if.sv
// Controller <-> datapath bundle: opcode and memory-ready in, control word out.
interface control_multi_wait_if #(parameter int STATE_W = 4);
  logic [6:0]         iOpcode;
  logic               iMemReady;
  logic               oEscreveIR;
  logic               oEscrevePC;
  logic               oEscrevePCCond;
  logic               oEscrevePCBack;
  logic [1:0]         oOrigAULA;
  logic [1:0]         oOrigBULA;
  logic [1:0]         oMem2Reg;
  logic               oOrigPC;
  logic               oIouD;
  logic               oRegWrite;
  logic               oMemWrite;
  logic               oMemRead;
  logic [1:0]         oALUOp;
  logic               oIllegal;
  logic [STATE_W-1:0] oState;

  modport master (
    input  iOpcode, iMemReady,
    output oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
           oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oIouD,
           oRegWrite, oMemWrite, oMemRead, oALUOp, oIllegal, oState
  );

  modport slave (
    output iOpcode, iMemReady,
    input  oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
           oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oIouD,
           oRegWrite, oMemWrite, oMemRead, oALUOp, oIllegal, oState
  );
endinterface

// File: rtl/control_multi_wait_mem_wait_counter.sv
// Memory-access wait tracker: either a fixed-latency cycle counter or a
// pass-through of the memory ready handshake.
module mem_wait_counter #(
  parameter int MEM_LAT   = 2,
  parameter int USE_READY = 0
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic clr,
  input  logic en,
  input  logic iMemReady,
  output logic done
);

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  logic [3:0] cnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 4'd1;
  end

  always_comb begin
    done = (USE_READY != 0) ? iMemReady : (cnt == LAST);
  end

endmodule

// File: rtl/control_multi_wait.sv
// Multicycle RISC-V control FSM with latency/ready-aware memory accesses,
// AUIPC support and an illegal-opcode trap.
module control_multi_wait
  import control_multi_wait_pkg::*;
#(
  parameter int MEM_LAT   = 2,
  parameter int USE_READY = 0,
  parameter int STATE_W   = 4
) (
  input logic                 iCLK,
  input logic                 iRST,
  control_multi_wait_if.master bus
);

  state_t state, nextState;
  ctrl_t  ctrlReg;
  logic   memDone, inAccess, fetchAdv;

  function automatic ctrl_t decodeState(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.escreveIR = 1'b1;
        c.memRead   = 1'b1;
        c.origAULA  = ORIGA_PC;
        c.origBULA  = ORIGB_FOUR;
        c.aluOp     = ALUOP_ADD;
      end
      ST_DECODE: begin
        c.origAULA = ORIGA_PCBACK;
        c.origBULA = ORIGB_IMM;
      end
      ST_ADDR: begin
        c.origAULA = ORIGA_RS1;
        c.origBULA = ORIGB_IMM;
      end
      ST_LW: begin
        c.iouD    = 1'b1;
        c.memRead = 1'b1;
      end
      ST_LWWB: begin
        c.mem2Reg  = M2R_MDR;
        c.regWrite = 1'b1;
      end
      ST_SW: begin
        c.iouD     = 1'b1;
        c.memWrite = 1'b1;
      end
      ST_RTYPE: begin
        c.origAULA = ORIGA_RS1;
        c.origBULA = ORIGB_RS2;
        c.aluOp    = ALUOP_FUNCT;
      end
      ST_OPIMM: begin
        c.origAULA = ORIGA_RS1;
        c.origBULA = ORIGB_IMM;
        c.aluOp    = ALUOP_FUNCT;
      end
      ST_LUI: begin
        c.origAULA = ORIGA_PC;
        c.origBULA = ORIGB_IMM;
        c.aluOp    = ALUOP_LUI;
      end
      ST_AUIPC: begin
        c.origAULA = ORIGA_PCBACK;
        c.origBULA = ORIGB_IMM;
        c.aluOp    = ALUOP_ADD;
      end
      ST_ALUWB: begin
        c.regWrite = 1'b1;
        c.mem2Reg  = M2R_ALUOUT;
      end
      ST_BRANCH: begin
        c.escrevePCCond = 1'b1;
        c.origAULA      = ORIGA_RS1;
        c.origBULA      = ORIGB_RS2;
        c.origPC        = 1'b1;
        c.aluOp         = ALUOP_BRANCH;
      end
      ST_JAL: begin
        c.escrevePC = 1'b1;
        c.origPC    = 1'b1;
        c.mem2Reg   = M2R_PC4;
        c.regWrite  = 1'b1;
      end
      ST_JALR: begin
        c.escrevePC = 1'b1;
        c.origAULA  = ORIGA_RS1;
        c.origBULA  = ORIGB_IMM;
        c.origPC    = 1'b0;
        c.mem2Reg   = M2R_PC4;
        c.regWrite  = 1'b1;
      end
      ST_ILLEGAL: c.illegal = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  assign inAccess = isAccess(state);

  mem_wait_counter #(
    .MEM_LAT  (MEM_LAT),
    .USE_READY(USE_READY)
  ) uWait (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .clr      (!inAccess || memDone),
    .en       (inAccess && !memDone),
    .iMemReady(bus.iMemReady),
    .done     (memDone)
  );

  always_comb begin
    nextState = ST_FETCH;
    case (state)
      ST_FETCH:  nextState = memDone ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (bus.iOpcode)
          OPC_LOAD, OPC_STORE: nextState = ST_ADDR;
          OPC_RTYPE:           nextState = ST_RTYPE;
          OPC_OPIMM:           nextState = ST_OPIMM;
          OPC_LUI:             nextState = ST_LUI;
          OPC_AUIPC:           nextState = ST_AUIPC;
          OPC_BRANCH:          nextState = ST_BRANCH;
          OPC_JAL:             nextState = ST_JAL;
          OPC_JALR:            nextState = ST_JALR;
          default:             nextState = ST_ILLEGAL;
        endcase
      end
      ST_ADDR:   nextState = (bus.iOpcode == OPC_LOAD) ? ST_LW : ST_SW;
      ST_LW:     nextState = memDone ? ST_LWWB : ST_LW;
      ST_SW:     nextState = memDone ? ST_FETCH : ST_SW;
      ST_RTYPE, ST_OPIMM, ST_LUI, ST_AUIPC: nextState = ST_ALUWB;
      ST_ILLEGAL: nextState = ST_ILLEGAL;
      default:   nextState = ST_FETCH;
    endcase
  end

  // Control word is registered from the next state, so it is valid for the whole state.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= ST_FETCH;
      ctrlReg <= decodeState(ST_FETCH);
    end else begin
      state   <= nextState;
      ctrlReg <= decodeState(nextState);
    end
  end

  // PC advance must land only in the completing fetch cycle, which is known only then.
  assign fetchAdv = (state == ST_FETCH) && memDone;

  assign bus.oEscreveIR     = ctrlReg.escreveIR;
  assign bus.oEscrevePC     = ctrlReg.escrevePC | fetchAdv;
  assign bus.oEscrevePCCond = ctrlReg.escrevePCCond;
  assign bus.oEscrevePCBack = ctrlReg.escrevePCBack | fetchAdv;
  assign bus.oOrigAULA      = ctrlReg.origAULA;
  assign bus.oOrigBULA      = ctrlReg.origBULA;
  assign bus.oMem2Reg       = ctrlReg.mem2Reg;
  assign bus.oOrigPC        = ctrlReg.origPC;
  assign bus.oIouD          = ctrlReg.iouD;
  assign bus.oRegWrite      = ctrlReg.regWrite;
  assign bus.oMemWrite      = ctrlReg.memWrite;
  assign bus.oMemRead       = ctrlReg.memRead;
  assign bus.oALUOp         = ctrlReg.aluOp;
  assign bus.oIllegal       = ctrlReg.illegal;
  assign bus.oState         = STATE_W'(state);

endmodule

// File: tb/tb_control_multi_wait.sv
// Scoreboarded bench for control_multi_wait: fixed latency 2 and 3, and ready handshake.
module tb_control_multi_wait;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_ADDR = 4'd2, S_LW = 4'd3,
                         S_LWWB = 4'd4, S_SW = 4'd5, S_RTYPE = 4'd6, S_OPIMM = 4'd7,
                         S_LUI = 4'd8, S_AUIPC = 4'd9, S_ALUWB = 4'd10, S_BRANCH = 4'd11,
                         S_JAL = 4'd12, S_JALR = 4'd13, S_ILLEGAL = 4'd14;

  localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_RTYPE = 7'b0110011,
                         O_OPIMM = 7'b0010011, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111,
                         O_BRANCH = 7'b1100011, O_JAL = 7'b1101111, O_JALR = 7'b1100111,
                         O_BAD = 7'b0001111;

  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  control_multi_wait_if #(.STATE_W(4)) bus2 ();
  control_multi_wait_if #(.STATE_W(4)) bus3 ();
  control_multi_wait_if #(.STATE_W(4)) busR ();

  control_multi_wait #(.MEM_LAT(2), .USE_READY(0), .STATE_W(4)) dut2 (.iCLK(iCLK), .iRST(iRST), .bus(bus2));
  control_multi_wait #(.MEM_LAT(3), .USE_READY(0), .STATE_W(4)) dut3 (.iCLK(iCLK), .iRST(iRST), .bus(bus3));
  control_multi_wait #(.MEM_LAT(2), .USE_READY(1), .STATE_W(4)) dutR (.iCLK(iCLK), .iRST(iRST), .bus(busR));

  wire [21:0] obs2 = {bus2.oState, bus2.oEscreveIR, bus2.oEscrevePC, bus2.oEscrevePCCond,
                      bus2.oEscrevePCBack, bus2.oOrigAULA, bus2.oOrigBULA, bus2.oMem2Reg,
                      bus2.oOrigPC, bus2.oIouD, bus2.oRegWrite, bus2.oMemWrite, bus2.oMemRead,
                      bus2.oALUOp, bus2.oIllegal};
  wire [21:0] obs3 = {bus3.oState, bus3.oEscreveIR, bus3.oEscrevePC, bus3.oEscrevePCCond,
                      bus3.oEscrevePCBack, bus3.oOrigAULA, bus3.oOrigBULA, bus3.oMem2Reg,
                      bus3.oOrigPC, bus3.oIouD, bus3.oRegWrite, bus3.oMemWrite, bus3.oMemRead,
                      bus3.oALUOp, bus3.oIllegal};
  wire [21:0] obsR = {busR.oState, busR.oEscreveIR, busR.oEscrevePC, busR.oEscrevePCCond,
                      busR.oEscrevePCBack, busR.oOrigAULA, busR.oOrigBULA, busR.oMem2Reg,
                      busR.oOrigPC, busR.oIouD, busR.oRegWrite, busR.oMemWrite, busR.oMemRead,
                      busR.oALUOp, busR.oIllegal};

  typedef struct {
    logic [21:0] exp;
    logic        rdy;
    string       name;
  } sb_t;

  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;

  // Expected state + control word, straight from the controller's output table.
  function automatic logic [21:0] expVec(logic [3:0] st, logic adv);
    logic       ir, pc, pcc, pcb, opc, iod, rw, mw, mr, ill;
    logic [1:0] a, b, m2r, alu;
    {ir, pc, pcc, pcb, opc, iod, rw, mw, mr, ill} = '0;
    {a, b, m2r, alu} = '0;
    case (st)
      S_FETCH:   begin ir = 1; pc = adv; pcb = adv; a = 2'b10; b = 2'b01; mr = 1; end
      S_DECODE:  begin a = 2'b00; b = 2'b10; end
      S_ADDR:    begin a = 2'b01; b = 2'b10; end
      S_LW:      begin iod = 1; mr = 1; end
      S_LWWB:    begin m2r = 2'b10; rw = 1; end
      S_SW:      begin iod = 1; mw = 1; end
      S_RTYPE:   begin a = 2'b01; b = 2'b00; alu = 2'b10; end
      S_OPIMM:   begin a = 2'b01; b = 2'b10; alu = 2'b10; end
      S_LUI:     begin a = 2'b10; b = 2'b10; alu = 2'b11; end
      S_AUIPC:   begin a = 2'b00; b = 2'b10; alu = 2'b00; end
      S_ALUWB:   begin rw = 1; end
      S_BRANCH:  begin pcc = 1; a = 2'b01; b = 2'b00; opc = 1; alu = 2'b01; end
      S_JAL:     begin pc = 1; opc = 1; m2r = 2'b01; rw = 1; end
      S_JALR:    begin pc = 1; a = 2'b01; b = 2'b10; m2r = 2'b01; rw = 1; end
      S_ILLEGAL: begin ill = 1; end
      default:   ;
    endcase
    return {st, ir, pc, pcc, pcb, a, b, m2r, opc, iod, rw, mw, mr, alu, ill};
  endfunction

  function automatic logic [21:0] obsOf(int sel);
    case (sel)
      0:       return obs2;
      1:       return obs3;
      default: return obsR;
    endcase
  endfunction

  function automatic void push(logic [3:0] st, logic adv, logic rdy, string nm);
    sb_t it;
    it.exp  = expVec(st, adv);
    it.rdy  = rdy;
    it.name = nm;
    sbq.push_back(it);
  endfunction

  // One whole instruction at fixed latency (ready driven on the completing cycles).
  function automatic void pushInstr(int lat, logic [6:0] op, string nm);
    for (int i = 0; i < lat; i++) push(S_FETCH, i == lat - 1, i == lat - 1, {nm, "_fetch"});
    push(S_DECODE, 1'b0, 1'b0, {nm, "_decode"});
    case (op)
      O_LOAD: begin
        push(S_ADDR, 0, 0, {nm, "_addr"});
        for (int i = 0; i < lat; i++) push(S_LW, 0, i == lat - 1, {nm, "_lw"});
        push(S_LWWB, 0, 0, {nm, "_lwwb"});
      end
      O_STORE: begin
        push(S_ADDR, 0, 0, {nm, "_addr"});
        for (int i = 0; i < lat; i++) push(S_SW, 0, i == lat - 1, {nm, "_sw"});
      end
      O_RTYPE:  begin push(S_RTYPE, 0, 0, {nm, "_ex"}); push(S_ALUWB, 0, 0, {nm, "_wb"}); end
      O_OPIMM:  begin push(S_OPIMM, 0, 0, {nm, "_ex"}); push(S_ALUWB, 0, 0, {nm, "_wb"}); end
      O_LUI:    begin push(S_LUI, 0, 0, {nm, "_ex"});   push(S_ALUWB, 0, 0, {nm, "_wb"}); end
      O_AUIPC:  begin push(S_AUIPC, 0, 0, {nm, "_ex"}); push(S_ALUWB, 0, 0, {nm, "_wb"}); end
      O_BRANCH: push(S_BRANCH, 0, 0, {nm, "_ex"});
      O_JAL:    push(S_JAL, 0, 0, {nm, "_ex"});
      O_JALR:   push(S_JALR, 0, 0, {nm, "_ex"});
      default:  push(S_ILLEGAL, 0, 0, {nm, "_trap"});
    endcase
  endfunction

  // Entered at posedge+1; each item is one clock cycle, checked at the falling edge.
  task automatic drain(int sel, logic [6:0] op);
    sb_t        it;
    logic [21:0] got;
    case (sel)
      0:       bus2.iOpcode = op;
      1:       bus3.iOpcode = op;
      default: busR.iOpcode = op;
    endcase
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      bus2.iMemReady = 1'($urandom_range(0, 1));
      bus3.iMemReady = 1'($urandom_range(0, 1));
      busR.iMemReady = (sel == 2) ? it.rdy : 1'b0;
      @(negedge iCLK);
      got = obsOf(sel);
      checks++;
      if (got !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, got, it.exp);
      end
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic doReset();
    busR.iMemReady = 1'b0;
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
  endtask

  task automatic test_reset();
    busR.iMemReady = 1'b0;
    bus2.iMemReady = 1'b1;
    bus3.iMemReady = 1'b1;
    iRST = 1'b1;
    #3;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (obsOf(s) !== expVec(S_FETCH, 1'b0)) begin
        errors++;
        $display("FAIL reset_dut%0d: got %h expected %h", s, obsOf(s), expVec(S_FETCH, 1'b0));
      end
    end
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
  endtask

  task automatic test_add();
    doReset();
    pushInstr(2, O_RTYPE, "add");
    drain(0, O_RTYPE);
  endtask

  task automatic test_back_to_back();
    pushInstr(2, O_OPIMM, "addi");
    drain(0, O_OPIMM);
    pushInstr(2, O_LUI, "lui");
    drain(0, O_LUI);
    pushInstr(2, O_STORE, "sw2");
    drain(0, O_STORE);
    pushInstr(2, O_JAL, "jal");
    drain(0, O_JAL);
  endtask

  task automatic test_lw_lat3();
    doReset();
    pushInstr(3, O_LOAD, "lw3");
    drain(1, O_LOAD);
    pushInstr(3, O_RTYPE, "add3");
    drain(1, O_RTYPE);
  endtask

  task automatic test_sw_ready();
    doReset();
    push(S_FETCH, 0, 0, "rsw_fetch_wait");
    push(S_FETCH, 1, 1, "rsw_fetch_done");
    push(S_DECODE, 0, 1, "rsw_decode_ready_pulse");
    push(S_ADDR, 0, 0, "rsw_addr");
    for (int i = 0; i < 4; i++) push(S_SW, 0, 0, "rsw_sw_wait");
    push(S_SW, 0, 1, "rsw_sw_done");
    push(S_FETCH, 0, 0, "rsw_next_fetch");
    drain(2, O_STORE);
    push(S_FETCH, 1, 1, "rlw_fetch");
    push(S_DECODE, 0, 0, "rlw_decode");
    push(S_ADDR, 0, 1, "rlw_addr");
    push(S_LW, 0, 1, "rlw_lw_1cycle");
    push(S_LWWB, 0, 0, "rlw_lwwb");
    drain(2, O_LOAD);
  endtask

  task automatic test_illegal();
    doReset();
    pushInstr(2, O_BAD, "illegal");
    for (int i = 0; i < 19; i++) push(S_ILLEGAL, 0, 0, "illegal_hold");
    drain(0, O_BAD);
    doReset();
    pushInstr(2, O_RTYPE, "after_trap");
    drain(0, O_RTYPE);
  endtask

  task automatic test_auipc_jalr_beq();
    doReset();
    pushInstr(2, O_AUIPC, "auipc");
    drain(0, O_AUIPC);
    pushInstr(2, O_JALR, "jalr");
    drain(0, O_JALR);
    pushInstr(2, O_BRANCH, "beq");
    drain(0, O_BRANCH);
  endtask

  task automatic test_reset_mid_lw();
    doReset();
    for (int i = 0; i < 3; i++) push(S_FETCH, i == 2, 0, "rlw3_fetch");
    push(S_DECODE, 0, 0, "rlw3_decode");
    push(S_ADDR, 0, 0, "rlw3_addr");
    push(S_LW, 0, 0, "rlw3_lw");
    push(S_LW, 0, 0, "rlw3_lw");
    drain(1, O_LOAD);
    #2;
    iRST = 1'b1;
    #1;
    checks++;
    if (obs3 !== expVec(S_FETCH, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid_lw_async: got %h expected %h", obs3, expVec(S_FETCH, 1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      checks++;
      if (obs3 !== expVec(S_FETCH, 1'b0)) begin
        errors++;
        $display("FAIL reset_mid_lw_hold: got %h expected %h", obs3, expVec(S_FETCH, 1'b0));
      end
    end
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    pushInstr(3, O_RTYPE, "post_reset_add");
    drain(1, O_RTYPE);
  endtask

  initial begin
    iRST = 1'b1;
    bus2.iOpcode = '0; bus3.iOpcode = '0; busR.iOpcode = '0;
    bus2.iMemReady = 1'b0; bus3.iMemReady = 1'b0; busR.iMemReady = 1'b0;
    @(posedge iCLK);
    #1;
    test_reset();
    test_add();
    test_back_to_back();
    test_lw_lat3();
    test_sw_ready();
    test_illegal();
    test_auipc_jalr_beq();
    test_reset_mid_lw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
